// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Optional byte-enable support is selected elsewhere with DMEM_BYTE_EN_EN.
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_t;

   localparam int unsigned BYTE_OFFSET     = 2;
   localparam int unsigned DEFAULT_LATENCY = 4;

   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous per-byte write, combinational read.
// Contents are not reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                                clk_i,
   input  logic                                we_i,
   input  logic [idx_width(DEPTH_WORDS)-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]               wdata_i,
   input  logic [DATA_WIDTH/8-1:0]             wbe_i,
   input  logic [idx_width(DEPTH_WORDS)-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]               rdata_o
);

   localparam int unsigned BE_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (wbe_i[b]) begin
               mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: fixed-latency access with busy stall and ack pulse.
// Define DMEM_BYTE_EN_EN to add the be_i port and byte-masked writes.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      req_i,
   input  logic                      we_i,
   input  logic [31:0]               addr_i,
   input  logic [DATA_WIDTH-1:0]     wdata_i,
`ifdef DMEM_BYTE_EN_EN
   input  logic [DATA_WIDTH/8-1:0]   be_i,
`endif
   output logic                      busy_o,
   output logic                      ack_o,
   output logic [DATA_WIDTH-1:0]     rdata_o
);

   localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_t           state;
   logic [CNT_W-1:0]      cnt;
   logic                  req_we;
   logic [IDX_W-1:0]      req_idx;
   logic [DATA_WIDTH-1:0] req_wdata;
`ifdef DMEM_BYTE_EN_EN
   logic [BE_W-1:0]       req_be;
`endif

   logic                  accept;
   logic                  enter_done;
   logic                  acc_we;
   logic [IDX_W-1:0]      acc_idx;
   logic [DATA_WIDTH-1:0] acc_wdata;
   logic [BE_W-1:0]       acc_be;
   logic [DATA_WIDTH-1:0] arr_rdata;
   logic                  addr_unused;

   assign addr_unused = ^addr_i;

   assign accept     = (state == ST_IDLE) && req_i;
   assign enter_done = ((state == ST_WAIT) && (cnt == CNT_W'(1)))
                     || (accept && (LATENCY == 1));

   // With LATENCY = 1 the access completes on the accepting edge, so the
   // array must see the live inputs rather than the request registers.
   always_comb begin
      acc_we    = req_we;
      acc_idx   = req_idx;
      acc_wdata = req_wdata;
`ifdef DMEM_BYTE_EN_EN
      acc_be    = req_be;
`else
      acc_be    = '1;
`endif
      if (state == ST_IDLE) begin
         acc_we    = we_i;
         acc_idx   = addr_i[BYTE_OFFSET +: IDX_W];
         acc_wdata = wdata_i;
`ifdef DMEM_BYTE_EN_EN
         acc_be    = be_i;
`endif
      end
   end

   dmem_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (enter_done && acc_we),
      .waddr_i (acc_idx),
      .wdata_i (acc_wdata),
      .wbe_i   (acc_be),
      .raddr_i (acc_idx),
      .rdata_o (arr_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         req_we    <= 1'b0;
         req_idx   <= '0;
         req_wdata <= '0;
`ifdef DMEM_BYTE_EN_EN
         req_be    <= '0;
`endif
         rdata_o   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_i) begin
                  req_we    <= we_i;
                  req_idx   <= addr_i[BYTE_OFFSET +: IDX_W];
                  req_wdata <= wdata_i;
`ifdef DMEM_BYTE_EN_EN
                  req_be    <= be_i;
`endif
                  if (LATENCY == 1) begin
                     state <= ST_DONE;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= CNT_W'(LATENCY - 1);
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (enter_done && !acc_we) begin
            rdata_o <= arr_rdata;
         end
      end
   end

   assign ack_o  = (state == ST_DONE);
   assign busy_o = rst_n_i && (accept || (state == ST_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level model plus directed vectors.
// Byte-enable vectors are included when DMEM_BYTE_EN_EN is defined.
module tb_dmem_responder;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned LAT   = 4;
   localparam int unsigned BW    = DW / 8;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          req   = 1'b0;
   logic          we    = 1'b0;
   logic [31:0]   addr  = '0;
   logic [DW-1:0] wdata = '0;
   logic [BW-1:0] be    = '1;
   logic          busy;
   logic          ack;
   logic [DW-1:0] rdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   dmem_responder #(
      .DATA_WIDTH  (DW),
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .req_i   (req),
      .we_i    (we),
      .addr_i  (addr),
      .wdata_i (wdata),
`ifdef DMEM_BYTE_EN_EN
      .be_i    (be),
`endif
      .busy_o  (busy),
      .ack_o   (ack),
      .rdata_o (rdata)
   );

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Transaction model: k counts edges since acceptance, accepting edge = 1;
   // the access completes on edge k == LAT and the next edge frees the slave.
   bit            m_active = 1'b0;
   int            m_k      = 0;
   bit            m_we;
   int unsigned   m_idx;
   logic [DW-1:0] m_wd;
   logic [BW-1:0] m_be;
   logic [DW-1:0] m_mem   [DEPTH];
   bit            m_known [DEPTH];
   logic [DW-1:0] m_rdata  = '0;
   bit            m_rknown = 1'b1;

   function automatic int unsigned word_of(input logic [31:0] a);
      return (a / 4) % DEPTH;
   endfunction

   task automatic commit(input bit w, input int unsigned i, input logic [DW-1:0] d,
                         input logic [BW-1:0] e);
      if (w) begin
         for (int b = 0; b < BW; b++)
            if (e[b]) m_mem[i][b*8 +: 8] <= d[b*8 +: 8];
         m_known[i] <= m_known[i] | (e == '1);
      end else begin
         m_rdata  <= m_mem[i];
         m_rknown <= m_known[i];
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_rdata  <= '0;
         m_rknown <= 1'b1;
      end else if (m_active) begin
         if (m_k == LAT) m_active <= 1'b0;
         else begin
            m_k <= m_k + 1;
            if (m_k + 1 == LAT) commit(m_we, m_idx, m_wd, m_be);
         end
      end else if (req) begin
         m_active <= 1'b1;
         m_k      <= 1;
         m_we     <= we;
         m_idx    <= word_of(addr);
         m_wd     <= wdata;
         m_be     <= be;
         if (LAT == 1) commit(we, word_of(addr), wdata, be);
      end
   end

   always @(negedge clk) begin
      chk("busy", DW'(busy), DW'(rst_n && ((!m_active && req) || (m_active && m_k < LAT))));
      chk("ack", DW'(ack), DW'(m_active && m_k == LAT));
      if (m_rknown) chk("rdata", rdata, m_rdata);
   end

   // Called just after the accepting edge; lat counts that edge as 1.
   task automatic wait_ack(output int lat);
      lat = 1;
      forever begin
         @(negedge clk);
         if (ack) break;
         if (lat >= 20) begin
            n_chk++;
            $display("FAIL ack_timeout: got no ack after %0d edges, required ack by %0d", lat, LAT);
            break;
         end
         @(posedge clk);
         lat++;
      end
   endtask

   // Inputs are scrambled after acceptance; they must have no effect.
   task automatic xact(input bit w, input logic [31:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] e, output logic [DW-1:0] rd, output int lat);
      @(posedge clk); #1;
      req = 1'b1; we = w; addr = a; wdata = d; be = e;
      @(posedge clk); #1;
      req = 1'b0; we = ~w; addr = $urandom; wdata = $urandom; be = ~e;
      wait_ack(lat);
      rd = rdata;
   endtask

   initial begin
      logic [DW-1:0] rd;
      int            lat;
      int            acks [$];

      // Reset held with a pending request
      req = 1'b1; we = 1'b1; addr = 32'h44; wdata = 32'h0BADF00D; be = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", DW'(busy), 0);
      chk("rst_ack", DW'(ack), 0);
      chk("rst_rdata", rdata, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk("accept_first_edge", DW'(busy), 1);
      @(posedge clk); #1;
      wait_ack(lat);
      chk("first_lat", lat, LAT - 1);

      // Basic write then read
      xact(1'b1, 32'h10, 32'hDEADBEEF, '1, rd, lat);
      chk("wr_lat", lat, 4);
      xact(1'b0, 32'h10, 32'h0, '1, rd, lat);
      chk("rd_lat", lat, 4);
      chk("rd_10", rd, 32'hDEADBEEF);

      // Wrap and alignment
      xact(1'b1, 32'h400, 32'h11111111, '1, rd, lat);
      xact(1'b0, 32'h000, 32'h0, '1, rd, lat);
      chk("wrap_000", rd, 32'h11111111);
      xact(1'b0, 32'h013, 32'h0, '1, rd, lat);
      chk("unaligned_013", rd, 32'hDEADBEEF);
      xact(1'b1, 32'h44, 32'h77777777, '1, rd, lat);
      chk("write_keeps_rdata", rd, 32'hDEADBEEF);

      // Reset two cycles after acceptance aborts an uncommitted write
      xact(1'b1, 32'h20, 32'hA5A5A5A5, '1, rd, lat);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = '1;
      @(posedge clk); #1 req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("abort_ack", DW'(ack), 0);
      chk("abort_rdata", rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      xact(1'b0, 32'h20, 32'h0, '1, rd, lat);
      chk("abort_kept", rd, 32'hA5A5A5A5);

      // req held high through DONE
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; addr = 32'h10; be = '1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ack) acks.push_back(i);
         @(posedge clk);
      end
      #1 req = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      chk("held_ack_count", acks.size(), 2);
      if (acks.size() == 2) begin
         chk("held_first_ack", acks[0], 4);
         chk("held_ack_gap", acks[1] - acks[0], 5);
      end

`ifdef DMEM_BYTE_EN_EN
      xact(1'b1, 32'h30, 32'hA5A5A5A5, 4'b1111, rd, lat);
      xact(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0011, rd, lat);
      xact(1'b0, 32'h30, 32'h0, 4'b1111, rd, lat);
      chk("be_0011", rd, 32'hA5A5FFFF);
      xact(1'b1, 32'h30, 32'h00000000, 4'b0000, rd, lat);
      chk("be_0000_lat", lat, 4);
      xact(1'b0, 32'h30, 32'h0, 4'b1111, rd, lat);
      chk("be_0000", rd, 32'hA5A5FFFF);
`endif

      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
